// File: rtl/status_flags_reg_pkg.sv
// rtl/status_flags_reg_pkg.sv - shared NZCV flag definitions for the status register slice
package status_flags_reg_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Packed {z, c, n, v}, matching the bit indices above
  typedef logic [3:0] flags_t;

  // Instructions with this condition never read the flags
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/status_flags_reg_save_stack.sv
// rtl/status_flags_reg_save_stack.sv - flag_save_stack: parameterised LIFO of saved flags
// Entries are not reset; only the occupancy count is.
module flag_save_stack
  import status_flags_reg_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flags_t          mem [DEPTH];
  logic   [AW-1:0] wr_idx;
  logic   [AW-1:0] rd_idx;

  assign wr_idx = AW'(count);
  assign rd_idx = AW'(count - CW'(1));
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/status_flags_reg.sv
// rtl/status_flags_reg.sv - NZCV status register with save stack and EXE->ID hazard handling
// Define SR_FWD_EN to forward in-flight flags to SR instead of requesting a stall.
module status_flags_reg
  import status_flags_reg_pkg::*;
#(
  parameter int SAVE_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            freeze,
  input  logic                            exe_s_en,
  input  logic [3:0]                      exe_flags,
  input  logic                            id_cond_valid,
  input  logic                            save_req,
  input  logic                            restore_req,
  output logic [3:0]                      SR,
  output logic                            sr_hazard,
  output logic [$clog2(SAVE_DEPTH+1)-1:0] save_depth,
  output logic                            stack_err
);

  localparam int DW = $clog2(SAVE_DEPTH + 1);

  flags_t          sr_q;
  flags_t          sr_d;
  flags_t          stack_top;
  logic            err_q;
  logic            err_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [DW-1:0]   depth;

  flag_save_stack #(
    .DEPTH (SAVE_DEPTH),
    .CW    (DW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (sr_q),
    .top   (stack_top),
    .full  (full),
    .empty (empty),
    .count (depth)
  );

  // A successful pop overrides the EXE write; every other case lets EXE land.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    sr_d  = sr_q;
    err_d = err_q;
    if (!freeze) begin
      if (exe_s_en) begin
        sr_d = exe_flags;
      end
      if (save_req && restore_req) begin
        err_d = 1'b1;
      end else if (restore_req) begin
        if (!empty) begin
          pop  = 1'b1;
          sr_d = stack_top;
        end else begin
          err_d = 1'b1;
        end
      end else if (save_req) begin
        if (!full) begin
          push = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      err_q <= err_d;
    end
  end

  assign stack_err  = err_q;
  assign save_depth = depth;

`ifdef SR_FWD_EN
  logic unused_id_cond_valid;
  assign unused_id_cond_valid = id_cond_valid;

  always_comb begin
    if (restore_req && !empty) begin
      SR = stack_top;
    end else if (exe_s_en) begin
      SR = exe_flags;
    end else begin
      SR = sr_q;
    end
  end
  assign sr_hazard = 1'b0;
`else
  assign SR        = sr_q;
  assign sr_hazard = id_cond_valid & (exe_s_en | restore_req);
`endif

endmodule

// File: tb/tb_status_flags_reg.sv
// tb/tb_status_flags_reg.sv - scoreboard bench for status_flags_reg (default and SR_FWD_EN builds)
module tb_status_flags_reg;

  localparam int SAVE_DEPTH = 2;
  localparam int DW = $clog2(SAVE_DEPTH + 1);
`ifdef SR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          freeze = 1'b0;
  logic          exe_s_en = 1'b0;
  logic [3:0]    exe_flags = 4'b0000;
  logic          id_cond_valid = 1'b0;
  logic          save_req = 1'b0;
  logic          restore_req = 1'b0;
  logic [3:0]    SR;
  logic          sr_hazard;
  logic [DW-1:0] save_depth;
  logic          stack_err;

  status_flags_reg #(.SAVE_DEPTH(SAVE_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .freeze        (freeze),
    .exe_s_en      (exe_s_en),
    .exe_flags     (exe_flags),
    .id_cond_valid (id_cond_valid),
    .save_req      (save_req),
    .restore_req   (restore_req),
    .SR            (SR),
    .sr_hazard     (sr_hazard),
    .save_depth    (save_depth),
    .stack_err     (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [3:0]    sr;
    logic          haz;
    logic [DW-1:0] dep;
    logic          err;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL monitor: output sampled with empty scoreboard");
      end else begin
        e = sb.pop_front();
        if ({SR, sr_hazard, save_depth, stack_err} !== {e.sr, e.haz, e.dep, e.err}) begin
          errors++;
          $display("FAIL %s: got SR=%b haz=%b depth=%0d err=%b, expected SR=%b haz=%b depth=%0d err=%b",
                   e.name, SR, sr_hazard, save_depth, stack_err, e.sr, e.haz, e.dep, e.err);
        end
      end
    end
  end

  task automatic drive(input logic sv, input logic rs, input logic ex, input logic [3:0] fl,
                       input logic idv, input logic frz);
    @(negedge clk);
    save_req      = sv;
    restore_req   = rs;
    exe_s_en      = ex;
    exe_flags     = fl;
    id_cond_valid = idv;
    freeze        = frz;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic [3:0] sr, input logic haz,
                            input int dep, input logic err);
    exp_t e;
    e.name = name;
    e.sr   = sr;
    e.haz  = haz;
    e.dep  = DW'(dep);
    e.err  = err;
    sb.push_back(e);
    #1;
    ->sample_ev;
    #1;
  endtask

  initial begin
    #2;
    expect_out("reset", 4'b0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 1, 4'b1010, 0, 0);
    expect_out("exe_comb", FWD ? 4'b1010 : 4'b0000, 1'b0, 0, 1'b0);
    idle();
    expect_out("exe_write", 4'b1010, 1'b0, 0, 1'b0);

    drive(0, 0, 1, 4'b0100, 0, 0);
    idle();
    expect_out("exe_0100", 4'b0100, 1'b0, 0, 1'b0);
    drive(1, 0, 1, 4'b0001, 0, 0);
    idle();
    expect_out("save_with_exe", 4'b0001, 1'b0, 1, 1'b0);
    drive(0, 1, 0, 4'b0000, 0, 0);
    expect_out("restore_comb", FWD ? 4'b0100 : 4'b0001, 1'b0, 1, 1'b0);
    idle();
    expect_out("restore", 4'b0100, 1'b0, 0, 1'b0);

    drive(1, 0, 0, 4'b0000, 0, 0);
    idle();
    expect_out("save1", 4'b0100, 1'b0, 1, 1'b0);
    drive(0, 0, 1, 4'b0110, 0, 0);
    idle();
    drive(1, 0, 0, 4'b0000, 0, 0);
    idle();
    expect_out("save2", 4'b0110, 1'b0, 2, 1'b0);
    drive(0, 0, 1, 4'b1100, 0, 0);
    idle();
    drive(1, 0, 0, 4'b0000, 0, 0);
    idle();
    expect_out("save_overflow", 4'b1100, 1'b0, 2, 1'b1);
    drive(0, 1, 0, 4'b0000, 0, 0);
    idle();
    expect_out("pop_top", 4'b0110, 1'b0, 1, 1'b1);
    drive(0, 1, 0, 4'b0000, 0, 0);
    idle();
    expect_out("pop_bottom", 4'b0100, 1'b0, 0, 1'b1);
    drive(0, 1, 1, 4'b0011, 0, 0);
    idle();
    expect_out("underflow_with_exe", 4'b0011, 1'b0, 0, 1'b1);
    drive(0, 1, 0, 4'b0000, 0, 0);
    idle();
    expect_out("underflow_hold", 4'b0011, 1'b0, 0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 0, 1, 4'b1111, 0, 1);
      expect_out("freeze_hold", FWD ? 4'b1111 : 4'b0011, 1'b0, 0, 1'b1);
    end
    drive(0, 0, 1, 4'b1111, 0, 0);
    expect_out("freeze_release_comb", FWD ? 4'b1111 : 4'b0011, 1'b0, 0, 1'b1);
    idle();
    expect_out("freeze_release", 4'b1111, 1'b0, 0, 1'b1);

    drive(0, 0, 1, 4'b1000, 1, 0);
    expect_out("hazard_exe", FWD ? 4'b1000 : 4'b1111, !FWD, 0, 1'b1);
    drive(0, 0, 0, 4'b0000, 1, 0);
    expect_out("hazard_resolved", 4'b1000, 1'b0, 0, 1'b1);
    drive(0, 1, 0, 4'b0000, 1, 0);
    expect_out("hazard_restore", 4'b1000, !FWD, 0, 1'b1);

    drive(1, 0, 0, 4'b0000, 0, 0);
    drive(1, 0, 0, 4'b0000, 0, 0);
    idle();
    expect_out("pre_reset", 4'b1000, 1'b0, 2, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_out("async_reset", 4'b0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 0, 0, 4'b0000, 0, 0);
    idle();
    expect_out("save_after_reset", 4'b0000, 1'b0, 1, 1'b0);
    drive(1, 1, 1, 4'b1001, 0, 0);
    idle();
    expect_out("conflict", 4'b1001, 1'b0, 1, 1'b1);
    drive(0, 1, 1, 4'b1111, 0, 0);
    idle();
    expect_out("restore_beats_exe", 4'b0000, 1'b0, 0, 1'b1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
